// File: rtl/cpu_mc_pkg.sv
// Shared encodings for the multi-cycle core: instruction modes, opcodes,
// instruction field positions and the sequencer state type.
package cpu_mc_pkg;

    localparam logic [1:0] MODE_RR   = 2'b00;
    localparam logic [1:0] MODE_IMM  = 2'b01;
    localparam logic [1:0] MODE_IFZ  = 2'b10;
    localparam logic [1:0] MODE_IFNZ = 2'b11;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_MOV  = 4'd8;
    localparam logic [3:0] OP_CMP  = 4'd9;
    localparam logic [3:0] OP_BR   = 4'd10;
    localparam logic [3:0] OP_NOP  = 4'd11;  // 11..14 all behave as NOP
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam int F_MODE_HI = 15;
    localparam int F_MODE_LO = 14;
    localparam int F_OP_HI   = 13;
    localparam int F_OP_LO   = 10;
    localparam int F_RD_HI   = 9;
    localparam int F_RD_LO   = 7;
    localparam int F_RS1_HI  = 6;
    localparam int F_RS1_LO  = 4;
    localparam int F_RS2_HI  = 3;
    localparam int F_RS2_LO  = 1;
    localparam int F_IMM_HI  = 3;
    localparam int F_IMM_LO  = 0;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // ops 0..8 produce a register result
    function automatic logic writes_rd(input logic [3:0] op);
        return op <= OP_MOV;
    endfunction

    // ops 0..9 update Z/C
    function automatic logic sets_flags(input logic [3:0] op);
        return op <= OP_CMP;
    endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational ALU for the multi-cycle core. Carry is the carry-out for ADD,
// the unsigned borrow for SUB/CMP and 0 otherwise.
module cpu_mc_alu
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [3:0]      shamt;

    assign shamt = b[3:0];

    // result and carry selection per opcode
    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                sum    = {1'b0, a} - {1'b0, b};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: result = (32'(shamt) >= 32'(DATA_W)) ? '0 : (a << shamt);
            OP_SHR: result = (32'(shamt) >= 32'(DATA_W)) ? '0 : (a >> shamt);
            OP_MOV: result = b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle core: fetch over a req/valid handshake, single-cycle execute,
// 8-entry register file, Z/C flags, conditional execution, branch and halt.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_FETCH | imem_req high, waiting for imem_valid; latch instruction word
// ST_EXEC  | execute ir, write rd/flags, advance pc, pulse retire
// ST_HALT  | stopped, no fetches; only reset leaves
module cpu_core_mc
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 7,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [15:0]       imem_data,
    output logic              retire,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];

    logic [1:0]        mode;
    logic [3:0]        op;
    logic [2:0]        rd, rs1, rs2;
    logic              cond_ok;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic              alu_zero, alu_carry;

    assign mode    = ir_q[F_MODE_HI:F_MODE_LO];
    assign op      = ir_q[F_OP_HI:F_OP_LO];
    assign rd      = ir_q[F_RD_HI:F_RD_LO];
    assign rs1     = ir_q[F_RS1_HI:F_RS1_LO];
    assign rs2     = ir_q[F_RS2_HI:F_RS2_LO];
    assign cond_ok = (mode == MODE_IFZ)  ? z_q  :
                     (mode == MODE_IFNZ) ? !z_q : 1'b1;
    assign alu_a   = regs_q[rs1];
    assign alu_b   = (mode == MODE_IMM) ?
                     {{(DATA_W-4){1'b0}}, ir_q[F_IMM_HI:F_IMM_LO]} : regs_q[rs2];

    cpu_mc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    // sequencer next-state, architectural updates and retire pulse
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        z_d     = z_q;
        c_d     = c_q;
        regs_d  = regs_q;
        retire  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (req_q && imem_valid) begin
                    ir_d    = imem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                retire = 1'b1;
                if (cond_ok && op == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = pc_q + ADDR_W'(1);
                    if (cond_ok) begin
                        if (writes_rd(op)) regs_d[rd] = alu_result;
                        if (sets_flags(op)) begin
                            z_d = alu_zero;
                            c_d = alu_carry;
                        end
                        if (op == OP_BR) pc_d = alu_a[ADDR_W-1:0];
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
        // registered so reset (or leaving FETCH) drops the request on the next edge
        req_d = (state_d == ST_FETCH);
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            req_q   <= 1'b0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
            req_q   <= req_d;
            regs_q  <= regs_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = (state_q == ST_HALT);
    assign dbg_data  = regs_q[dbg_sel];

endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc: table of single-step instruction vectors on
// a zero-wait ROM, then hand sequences for wait states, reset and halt.
module tb_cpu_core_mc;

    localparam int DW = 16;
    localparam int AW = 7;

    logic          clk;
    logic          rst_n;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_valid;
    logic [15:0]   imem_data;
    logic          retire;
    logic          halted;
    logic [AW-1:0] pc;
    logic [2:0]    dbg_sel;
    logic [DW-1:0] dbg_data;

    cpu_core_mc #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .retire     (retire),
        .halted     (halted),
        .pc         (pc),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #10 clk = ~clk;

    // instruction memory model with programmable wait cycles
    logic [15:0] rom [128];
    int          waits;
    int          wcnt;
    logic        spur;
    int          cyc;

    assign imem_data  = rom[imem_addr];
    assign imem_valid = (imem_req && wcnt >= waits) || spur;

    always @(posedge clk) begin
        if (imem_req && !imem_valid) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
        cyc <= cyc + 1;
    end

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] word;
        logic [2:0]  sel;
        logic [15:0] exp_val;
        logic        exp_z;
        logic        exp_c;
        logic [6:0]  exp_pc;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [15:0] enc(input logic [1:0] m, input logic [3:0] op,
                                        input logic [2:0] rd, input logic [2:0] rs1,
                                        input logic [3:0] low);
        return {m, op, rd, rs1, low};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else passed++;
    endtask

    task automatic wait_retire(output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (retire) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            $display("FAIL retire_timeout actual=no_retire required=retire_within_20");
        end
    endtask

    // one instruction through a 3-wait fetch, optionally with a stray valid in EXEC
    task automatic fetch_exec(input int k, input logic [6:0] a, input logic do_spur);
        for (int w = 0; w <= 3; w++) begin
            @(negedge clk);
            chk($sformatf("w%0d_req_held_%0d", k, w), 32'(imem_req), 32'd1);
            chk($sformatf("w%0d_addr_stable_%0d", k, w), 32'(imem_addr), 32'(a));
            chk($sformatf("w%0d_no_retire_%0d", k, w), 32'(retire), 32'd0);
        end
        @(negedge clk);
        chk($sformatf("w%0d_retire", k), 32'(retire), 32'd1);
        chk($sformatf("w%0d_req_low_exec", k), 32'(imem_req), 32'd0);
        if (do_spur) begin
            spur = 1'b1;
            @(posedge clk);
            #1 spur = 1'b0;
        end
    endtask

    initial begin
        logic ok;
        int   last_cyc;
        clk     = 1'b0;
        rst_n   = 1'b0;
        waits   = 0;
        wcnt    = 0;
        spur    = 1'b0;
        cyc     = 0;
        dbg_sel = '0;

        vecs[0]  = '{7'h00, enc(2'b01, 4'd8,  3'd1, 3'd0, 4'd5),  3'd1, 16'h0005,   1'b0, 1'b0, 7'h01};
        vecs[1]  = '{7'h01, enc(2'b01, 4'd8,  3'd2, 3'd0, 4'd3),  3'd2, 16'h0003,   1'b0, 1'b0, 7'h02};
        vecs[2]  = '{7'h02, enc(2'b00, 4'd0,  3'd3, 3'd1, 4'd4),  3'd3, 16'h0008,   1'b0, 1'b0, 7'h03};
        vecs[3]  = '{7'h03, enc(2'b00, 4'd1,  3'd4, 3'd2, 4'd2),  3'd4, 16'hFFFE,   1'b0, 1'b1, 7'h04};
        vecs[4]  = '{7'h04, enc(2'b00, 4'd0,  3'd0, 3'd4, 4'd2),  3'd0, 16'h0003,   1'b0, 1'b1, 7'h05};
        vecs[5]  = '{7'h05, enc(2'b01, 4'd8,  3'd7, 3'd0, 4'd7),  3'd7, 16'h0007,   1'b0, 1'b0, 7'h06};
        vecs[6]  = '{7'h06, enc(2'b00, 4'd9,  3'd6, 3'd1, 4'd2),  3'd6, 16'h0000,   1'b1, 1'b0, 7'h07};
        vecs[7]  = '{7'h07, enc(2'b11, 4'd8,  3'd6, 3'd0, 4'd14), 3'd6, 16'h0000,   1'b1, 1'b0, 7'h08};
        vecs[8]  = '{7'h08, enc(2'b10, 4'd8,  3'd5, 3'd0, 4'd14), 3'd5, 16'h0007,   1'b0, 1'b0, 7'h09};
        vecs[9]  = '{7'h09, enc(2'b01, 4'd8,  3'd7, 3'd0, 4'd15), 3'd7, 16'h000F,   1'b0, 1'b0, 7'h0A};
        vecs[10] = '{7'h0A, enc(2'b01, 4'd6,  3'd7, 3'd7, 4'd3),  3'd7, 16'h0078,   1'b0, 1'b0, 7'h0B};
        vecs[11] = '{7'h0B, enc(2'b01, 4'd3,  3'd7, 3'd7, 4'd7),  3'd7, 16'h007F,   1'b0, 1'b0, 7'h0C};
        vecs[12] = '{7'h0C, enc(2'b00, 4'd10, 3'd0, 3'd7, 4'd0),  3'd0, 16'h0003,   1'b0, 1'b0, 7'h7F};
        vecs[13] = '{7'h7F, enc(2'b00, 4'd11, 3'd3, 3'd0, 4'd0),  3'd3, 16'h0008,   1'b0, 1'b0, 7'h00};

        for (int i = 0; i < 128; i++) rom[i] = enc(2'b00, 4'd11, 3'd0, 3'd0, 4'd0);
        for (int i = 0; i < 14; i++) rom[vecs[i].addr] = vecs[i].word;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        for (int r = 0; r < 8; r++) begin
            dbg_sel = 3'(r);
            #1 chk($sformatf("rst_reg%0d", r), 32'(dbg_data), 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;

        // zero-wait program, one vector per retired instruction
        last_cyc = 0;
        for (int i = 0; i < 14; i++) begin
            wait_retire(ok);
            if (!ok) break;
            if (i > 0) chk($sformatf("v%0d_retire_spacing", i), 32'(cyc - last_cyc), 32'd2);
            last_cyc = cyc;
            dbg_sel  = vecs[i].sel;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_reg%0d", i, vecs[i].sel), 32'(dbg_data), 32'(vecs[i].exp_val));
            chk($sformatf("v%0d_z", i), 32'(dut.z_q), 32'(vecs[i].exp_z));
            chk($sformatf("v%0d_c", i), 32'(dut.c_q), 32'(vecs[i].exp_c));
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            chk($sformatf("v%0d_imem_addr", i), 32'(imem_addr), 32'(vecs[i].exp_pc));
        end

        // stall the fetch at 0, then reset in the middle of it
        waits = 3;
        rom[0] = enc(2'b01, 4'd8,  3'd1, 3'd0, 4'd9);
        rom[1] = enc(2'b00, 4'd0,  3'd2, 3'd1, 4'd2);
        rom[2] = enc(2'b01, 4'd7,  3'd3, 3'd2, 4'd2);
        rom[3] = enc(2'b00, 4'd4,  3'd4, 3'd3, 4'd2);
        rom[4] = enc(2'b00, 4'd15, 3'd0, 3'd0, 4'd0);
        @(negedge clk);
        chk("midfetch_req", 32'(imem_req), 32'd1);
        chk("midfetch_addr", 32'(imem_addr), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_req_drop", 32'(imem_req), 32'd0);
        chk("midrst_pc", 32'(pc), 32'd0);
        chk("midrst_z", 32'(dut.z_q), 32'd0);
        for (int r = 0; r < 8; r++) begin
            dbg_sel = 3'(r);
            #1 chk($sformatf("midrst_reg%0d", r), 32'(dbg_data), 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;

        // 3-wait memory, stray valid during EXEC, ending in HALT at 4
        fetch_exec(0, 7'd0, 1'b0);
        fetch_exec(1, 7'd1, 1'b1);
        fetch_exec(2, 7'd2, 1'b0);
        fetch_exec(3, 7'd3, 1'b1);
        fetch_exec(4, 7'd4, 1'b0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk($sformatf("halt_halted_%0d", n), 32'(halted), 32'd1);
            chk($sformatf("halt_req_%0d", n), 32'(imem_req), 32'd0);
        end
        chk("halt_pc", 32'(pc), 32'd4);
        dbg_sel = 3'd1;
        #1 chk("w_reg1", 32'(dbg_data), 32'h0009);
        dbg_sel = 3'd2;
        #1 chk("w_reg2", 32'(dbg_data), 32'h0012);
        dbg_sel = 3'd3;
        #1 chk("w_reg3", 32'(dbg_data), 32'h0004);
        dbg_sel = 3'd4;
        #1 chk("w_reg4", 32'(dbg_data), 32'h000D);
        chk("w_z", 32'(dut.z_q), 32'd0);
        chk("w_c", 32'(dut.c_q), 32'd0);

        // reset out of HALT, fetch resumes at 0
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("unhalt_halted", 32'(halted), 32'd0);
        chk("unhalt_pc", 32'(pc), 32'd0);
        dbg_sel = 3'd4;
        #1 chk("unhalt_reg4", 32'(dbg_data), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", 32'(imem_addr), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
